// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the hazard controller and the EX operand muxes.
// Forward-select encoding must match the datapath mux wiring.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle.
// master = datapath side, slave = controller side.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import pipeline_hazard_ctrl_pkg::*;

  reg_idx_t id_rs;
  reg_idx_t id_rt;
  logic     id_uses_rt;
  reg_idx_t ex_rs;
  reg_idx_t ex_rt;
  logic     idex_memread;
  reg_idx_t idex_dst;
  logic     exmem_regwrite;
  reg_idx_t exmem_dst;
  logic     memwb_regwrite;
  reg_idx_t memwb_dst;
  logic     branch_taken;

  logic     pc_write;
  logic     ifid_write;
  logic     ifid_flush;
  logic     idex_bubble;
  logic     exmem_flush;
  fwd_sel_t fwd_a;
  fwd_sel_t fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_rs, ex_rt,
    output idex_memread, idex_dst,
    output exmem_regwrite, exmem_dst,
    output memwb_regwrite, memwb_dst,
    output branch_taken,
    input  pc_write, ifid_write, ifid_flush,
    input  idex_bubble, exmem_flush,
    input  fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_rs, ex_rt,
    input  idex_memread, idex_dst,
    input  exmem_regwrite, exmem_dst,
    input  memwb_regwrite, memwb_dst,
    input  branch_taken,
    output pc_write, ifid_write, ifid_flush,
    output idex_bubble, exmem_flush,
    output fwd_a, fwd_b, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// EX operand forwarding compare, two lanes (OP1 from rs, OP2 from rt).
// EX/MEM is checked first so the youngest producer wins.
module pipeline_hazard_ctrl_fwd_unit
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic     v_mem_i,
  input  logic     v_wb_i,
  input  logic     exmem_regwrite_i,
  input  reg_idx_t exmem_dst_i,
  input  logic     memwb_regwrite_i,
  input  reg_idx_t memwb_dst_i,
  input  reg_idx_t ex_rs_i,
  input  reg_idx_t ex_rt_i,
  output fwd_sel_t fwd_a_o,
  output fwd_sel_t fwd_b_o
);

  logic mem_ok;
  logic wb_ok;

  assign mem_ok = v_mem_i & exmem_regwrite_i
                & (exmem_dst_i != '0);
  assign wb_ok  = v_wb_i & memwb_regwrite_i
                & (memwb_dst_i != '0);

  always_comb begin
    fwd_a_o = FWD_RF;
    fwd_b_o = FWD_RF;
    if (mem_ok && exmem_dst_i == ex_rs_i)
      fwd_a_o = FWD_EXMEM;
    else if (wb_ok && memwb_dst_i == ex_rs_i)
      fwd_a_o = FWD_MEMWB;
    if (mem_ok && exmem_dst_i == ex_rt_i)
      fwd_b_o = FWD_EXMEM;
    else if (wb_ok && memwb_dst_i == ex_rt_i)
      fwd_b_o = FWD_MEMWB;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall, branch flush and forwarding control for the
// 5-stage pipeline, with per-stage valid tracking and perf counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input logic clk,
  input logic rst,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL_CYCLES - 1);

  hz_state_t  state_q, state_d;
  logic [1:0] left_q, left_d;
  logic       v_id_q, v_ex_q, v_mem_q, v_wb_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic lu;
  logic pc_we, ifid_we, ifid_fl, bubble, exmem_fl;

  assign lu = v_ex_q & (state_q != FLUSH)
            & hz.idex_memread & (hz.idex_dst != '0)
            & ((hz.idex_dst == hz.id_rs)
              | (hz.id_uses_rt & (hz.idex_dst == hz.id_rt)));

  always_comb begin
    pc_we    = 1'b1;
    ifid_we  = 1'b1;
    ifid_fl  = 1'b0;
    bubble   = 1'b0;
    exmem_fl = 1'b0;
    state_d  = state_q;
    left_d   = left_q;
    if (hz.branch_taken) begin
      ifid_fl  = 1'b1;
      bubble   = 1'b1;
      exmem_fl = 1'b1;
      state_d  = FLUSH;
    end else begin
      unique case (state_q)
        RUN: if (lu) begin
          pc_we   = 1'b0;
          ifid_we = 1'b0;
          bubble  = 1'b1;
          left_d  = STALL_INIT;
          state_d = (STALL_INIT == 2'd0) ? RUN : STALL;
        end
        STALL: begin
          pc_we   = 1'b0;
          ifid_we = 1'b0;
          bubble  = 1'b1;
          left_d  = left_q - 2'd1;
          if (left_q == 2'd1) state_d = RUN;
        end
        FLUSH:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end
    // Reset dominates so buffers holding junk cannot stall or flush.
    if (rst) begin
      pc_we    = 1'b1;
      ifid_we  = 1'b1;
      ifid_fl  = 1'b0;
      bubble   = 1'b0;
      exmem_fl = 1'b0;
      state_d  = RUN;
      left_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      left_q      <= '0;
      v_id_q      <= 1'b0;
      v_ex_q      <= 1'b0;
      v_mem_q     <= 1'b0;
      v_wb_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      v_wb_q  <= v_mem_q;
      v_mem_q <= v_ex_q & ~exmem_fl;
      v_ex_q  <= v_id_q & ~bubble;
      if (ifid_fl)      v_id_q <= 1'b0;
      else if (ifid_we) v_id_q <= 1'b1;
      if (!pc_we && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (hz.branch_taken && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  pipeline_hazard_ctrl_fwd_unit u_fwd (
    .v_mem_i          (v_mem_q & ~rst),
    .v_wb_i           (v_wb_q & ~rst),
    .exmem_regwrite_i (hz.exmem_regwrite),
    .exmem_dst_i      (hz.exmem_dst),
    .memwb_regwrite_i (hz.memwb_regwrite),
    .memwb_dst_i      (hz.memwb_dst),
    .ex_rs_i          (hz.ex_rs),
    .ex_rt_i          (hz.ex_rt),
    .fwd_a_o          (hz.fwd_a),
    .fwd_b_o          (hz.fwd_b)
  );

  assign hz.pc_write    = pc_we;
  assign hz.ifid_write  = ifid_we;
  assign hz.ifid_flush  = ifid_fl;
  assign hz.idex_bubble = bubble;
  assign hz.exmem_flush = exmem_fl;
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: three controllers (1-cycle, 3-cycle, 2-bit counters)
// share one stimulus stream; each scenario checks the relevant copy.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0] id_rs, id_rt, ex_rs, ex_rt;
  logic [4:0] idex_dst, exmem_dst, memwb_dst;
  logic id_uses_rt, idex_memread, exmem_regwrite;
  logic memwb_regwrite, branch_taken;
  logic [39:0] stim;

  int chk = 0;
  int err = 0;

  assign stim = {id_rs, id_rt, id_uses_rt, ex_rs, ex_rt,
                 idex_memread, idex_dst, exmem_regwrite,
                 exmem_dst, memwb_regwrite, memwb_dst,
                 branch_taken};

  pipeline_hazard_ctrl_if #(.CNT_W(16)) if1();
  pipeline_hazard_ctrl_if #(.CNT_W(16)) if3();
  pipeline_hazard_ctrl_if #(.CNT_W(2))  ifs();

  assign {if1.id_rs, if1.id_rt, if1.id_uses_rt, if1.ex_rs,
          if1.ex_rt, if1.idex_memread, if1.idex_dst,
          if1.exmem_regwrite, if1.exmem_dst, if1.memwb_regwrite,
          if1.memwb_dst, if1.branch_taken} = stim;
  assign {if3.id_rs, if3.id_rt, if3.id_uses_rt, if3.ex_rs,
          if3.ex_rt, if3.idex_memread, if3.idex_dst,
          if3.exmem_regwrite, if3.exmem_dst, if3.memwb_regwrite,
          if3.memwb_dst, if3.branch_taken} = stim;
  assign {ifs.id_rs, ifs.id_rt, ifs.id_uses_rt, ifs.ex_rs,
          ifs.ex_rt, ifs.idex_memread, ifs.idex_dst,
          ifs.exmem_regwrite, ifs.exmem_dst, ifs.memwb_regwrite,
          ifs.memwb_dst, ifs.branch_taken} = stim;

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .hz(if1));
  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .hz(if3));
  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(2)) us (
    .clk(clk), .rst(rst), .hz(ifs));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rt = 0;
    ex_rs = 0; ex_rt = 0;
    idex_memread = 0; idex_dst = 0;
    exmem_regwrite = 0; exmem_dst = 0;
    memwb_regwrite = 0; memwb_dst = 0;
    branch_taken = 0;
  endtask

  // Reset, then four idle cycles so every stage is valid.
  task automatic do_reset();
    rst = 1'b1;
    idle();
    cyc();
    cyc();
    rst = 1'b0;
    repeat (4) cyc();
  endtask

  // lw $2 in EX, add $3,$2,$4 in ID.
  task automatic set_lu();
    idex_memread = 1; idex_dst = 5'd2;
    id_rs = 5'd2; id_rt = 5'd4; id_uses_rt = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    for (int i = 0; i < 3; i++) begin
      exmem_dst = 5'($urandom_range(31));
      memwb_dst = 5'($urandom_range(31));
      idex_dst  = 5'($urandom_range(31));
      exmem_regwrite = 1'($urandom_range(1));
      memwb_regwrite = 1'($urandom_range(1));
      idex_memread   = 1'($urandom_range(1));
      ex_rs = exmem_dst; ex_rt = memwb_dst; id_rs = idex_dst;
      #1;
      chk++;
      if (if1.pc_write !== 1'b1 || if1.ifid_write !== 1'b1) begin
        err++;
        $display("FAIL rst_hold_we got %b%b want 11",
                 if1.pc_write, if1.ifid_write);
      end
      chk++;
      if ({if1.fwd_a, if1.fwd_b} !== 4'b0000
          || if1.idex_bubble !== 1'b0) begin
        err++;
        $display("FAIL rst_hold_fwd got %b %b want 00 00",
                 if1.fwd_a, if1.fwd_b);
      end
      cyc();
    end
    chk++;
    if (if1.stall_cnt !== 16'd0 || if1.flush_cnt !== 16'd0) begin
      err++;
      $display("FAIL rst_cnt got %0d %0d want 0 0",
               if1.stall_cnt, if1.flush_cnt);
    end
    rst = 1'b0;
    idle();
    ex_rs = 5'd3; exmem_regwrite = 1; exmem_dst = 5'd3;
    ex_rt = 5'd4; memwb_regwrite = 1; memwb_dst = 5'd4;
    for (int k = 0; k < 5; k++) begin
      logic [1:0] ea, eb;
      ea = (k >= 3) ? 2'b10 : 2'b00;
      eb = (k >= 4) ? 2'b01 : 2'b00;
      #1;
      chk++;
      if (if1.fwd_a !== ea || if1.fwd_b !== eb
          || if1.pc_write !== 1'b1) begin
        err++;
        $display("FAIL rel_fill k=%0d got %b %b pc=%b want %b %b pc=1",
                 k, if1.fwd_a, if1.fwd_b, if1.pc_write, ea, eb);
      end
      cyc();
    end
    idle();
  endtask

  task automatic test_load_use();
    do_reset();
    set_lu();
    #1;
    chk++;
    if ({if1.pc_write, if1.ifid_write, if1.idex_bubble} !== 3'b001) begin
      err++;
      $display("FAIL lu_stall got %b%b%b want 001",
               if1.pc_write, if1.ifid_write, if1.idex_bubble);
    end
    chk++;
    if (if3.pc_write !== 1'b0) begin
      err++;
      $display("FAIL lu3_c1 got %b want 0", if3.pc_write);
    end
    cyc();
    idex_memread = 0; idex_dst = 0;
    exmem_regwrite = 1; exmem_dst = 5'd2;
    #1;
    chk++;
    if (if1.pc_write !== 1'b1 || if1.stall_cnt !== 16'd1) begin
      err++;
      $display("FAIL lu_once got pc=%b cnt=%0d want pc=1 cnt=1",
               if1.pc_write, if1.stall_cnt);
    end
    chk++;
    if (if3.pc_write !== 1'b0) begin
      err++;
      $display("FAIL lu3_c2 got %b want 0", if3.pc_write);
    end
    cyc();
    id_rs = 0; id_rt = 0; id_uses_rt = 0;
    ex_rs = 5'd2; ex_rt = 5'd4;
    exmem_regwrite = 0; exmem_dst = 0;
    memwb_regwrite = 1; memwb_dst = 5'd2;
    #1;
    chk++;
    if (if1.fwd_a !== 2'b01 || if1.fwd_b !== 2'b00) begin
      err++;
      $display("FAIL lu_fwd got %b %b want 01 00",
               if1.fwd_a, if1.fwd_b);
    end
    chk++;
    if (if3.pc_write !== 1'b0) begin
      err++;
      $display("FAIL lu3_c3 got %b want 0", if3.pc_write);
    end
    cyc();
    idle();
    #1;
    chk++;
    if (if3.pc_write !== 1'b1 || if3.stall_cnt !== 16'd3) begin
      err++;
      $display("FAIL lu3_end got pc=%b cnt=%0d want pc=1 cnt=3",
               if3.pc_write, if3.stall_cnt);
    end
    chk++;
    if (if1.stall_cnt !== 16'd1) begin
      err++;
      $display("FAIL lu_cnt got %0d want 1", if1.stall_cnt);
    end
    cyc();
  endtask

  task automatic test_fwd_priority();
    do_reset();
    ex_rs = 5'd5; ex_rt = 5'd5;
    exmem_regwrite = 1; exmem_dst = 5'd5;
    memwb_regwrite = 1; memwb_dst = 5'd5;
    #1;
    chk++;
    if (if1.fwd_a !== 2'b10 || if1.fwd_b !== 2'b10) begin
      err++;
      $display("FAIL fwd_prio got %b %b want 10 10",
               if1.fwd_a, if1.fwd_b);
    end
    exmem_dst = 5'd6;
    #1;
    chk++;
    if (if1.fwd_a !== 2'b01 || if1.fwd_b !== 2'b01) begin
      err++;
      $display("FAIL fwd_wb got %b %b want 01 01",
               if1.fwd_a, if1.fwd_b);
    end
    ex_rs = 5'd6; ex_rt = 5'd7;
    #1;
    chk++;
    if (if1.fwd_a !== 2'b10 || if1.fwd_b !== 2'b00) begin
      err++;
      $display("FAIL fwd_mix got %b %b want 10 00",
               if1.fwd_a, if1.fwd_b);
    end
    exmem_regwrite = 0;
    #1;
    chk++;
    if (if1.fwd_a !== 2'b00) begin
      err++;
      $display("FAIL fwd_norw got %b want 00", if1.fwd_a);
    end
    exmem_regwrite = 1; exmem_dst = 0; memwb_dst = 0;
    ex_rs = 0; ex_rt = 0;
    #1;
    chk++;
    if (if1.fwd_a !== 2'b00 || if1.fwd_b !== 2'b00) begin
      err++;
      $display("FAIL fwd_r0 got %b %b want 00 00",
               if1.fwd_a, if1.fwd_b);
    end
    idle();
    cyc();
  endtask

  task automatic test_branch();
    do_reset();
    branch_taken = 1;
    #1;
    chk++;
    if ({if1.ifid_flush, if1.idex_bubble, if1.exmem_flush,
         if1.pc_write, if1.ifid_write} !== 5'b11111) begin
      err++;
      $display("FAIL br_flush got %b%b%b%b%b want 11111",
               if1.ifid_flush, if1.idex_bubble, if1.exmem_flush,
               if1.pc_write, if1.ifid_write);
    end
    cyc();
    branch_taken = 0;
    set_lu();
    #1;
    chk++;
    if (if1.pc_write !== 1'b1 || if1.idex_bubble !== 1'b0) begin
      err++;
      $display("FAIL br_mask got pc=%b bub=%b want pc=1 bub=0",
               if1.pc_write, if1.idex_bubble);
    end
    chk++;
    if (if1.flush_cnt !== 16'd1) begin
      err++;
      $display("FAIL br_cnt got %0d want 1", if1.flush_cnt);
    end
    cyc();
    #1;
    chk++;
    if (if1.pc_write !== 1'b1) begin
      err++;
      $display("FAIL br_after got %b want 1", if1.pc_write);
    end
    do_reset();
    set_lu();
    branch_taken = 1;
    #1;
    chk++;
    if (if1.pc_write !== 1'b1 || if1.ifid_flush !== 1'b1) begin
      err++;
      $display("FAIL br_vs_lu got pc=%b fl=%b want pc=1 fl=1",
               if1.pc_write, if1.ifid_flush);
    end
    cyc();
    idle();
    #1;
    chk++;
    if (if1.stall_cnt !== 16'd0 || if1.flush_cnt !== 16'd1) begin
      err++;
      $display("FAIL br_vs_lu_cnt got %0d %0d want 0 1",
               if1.stall_cnt, if1.flush_cnt);
    end
    cyc();
  endtask

  task automatic test_branch_in_stall();
    do_reset();
    set_lu();
    #1;
    chk++;
    if (if3.pc_write !== 1'b0) begin
      err++;
      $display("FAIL bis_start got %b want 0", if3.pc_write);
    end
    cyc();
    idle();
    branch_taken = 1;
    #1;
    chk++;
    if (if3.pc_write !== 1'b1 || if3.ifid_flush !== 1'b1) begin
      err++;
      $display("FAIL bis_abort got pc=%b fl=%b want pc=1 fl=1",
               if3.pc_write, if3.ifid_flush);
    end
    cyc();
    branch_taken = 0;
    #1;
    chk++;
    if (if3.pc_write !== 1'b1 || if3.stall_cnt !== 16'd1
        || if3.flush_cnt !== 16'd1) begin
      err++;
      $display("FAIL bis_after got pc=%b s=%0d f=%0d want 1 1 1",
               if3.pc_write, if3.stall_cnt, if3.flush_cnt);
    end
    cyc();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_lu();
    cyc();
    rst = 1'b1;
    idle();
    #1;
    chk++;
    if (if3.pc_write !== 1'b1) begin
      err++;
      $display("FAIL rms_hold got %b want 1", if3.pc_write);
    end
    cyc();
    rst = 1'b0;
    #1;
    chk++;
    if (if3.pc_write !== 1'b1 || if3.stall_cnt !== 16'd0) begin
      err++;
      $display("FAIL rms_run got pc=%b cnt=%0d want pc=1 cnt=0",
               if3.pc_write, if3.stall_cnt);
    end
    cyc();
  endtask

  task automatic test_saturation();
    do_reset();
    set_lu();
    // Each bubble invalidates EX, so a held hazard re-fires every other cycle.
    for (int i = 0; i < 10; i++) begin
      logic exp_pc;
      exp_pc = (i % 2 == 0) ? 1'b0 : 1'b1;
      #1;
      chk++;
      if (if1.pc_write !== exp_pc) begin
        err++;
        $display("FAIL sat_pat i=%0d got %b want %b",
                 i, if1.pc_write, exp_pc);
      end
      cyc();
    end
    idle();
    #1;
    chk++;
    if (ifs.stall_cnt !== 2'd3) begin
      err++;
      $display("FAIL sat_cnt got %0d want 3", ifs.stall_cnt);
    end
    chk++;
    if (if1.stall_cnt !== 16'd5) begin
      err++;
      $display("FAIL sat_wide got %0d want 5", if1.stall_cnt);
    end
    rst = 1'b1;
    cyc();
    #1;
    chk++;
    if (ifs.stall_cnt !== 2'd0) begin
      err++;
      $display("FAIL sat_rst got %0d want 0", ifs.stall_cnt);
    end
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_fwd_priority();
    test_branch();
    test_branch_in_stall();
    test_reset_mid_stall();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
